// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for a 5-stage LEGv8 pipeline: load-use stalls,
// MEM-stage branch flushes, data-memory waits with timeout halt, and perf counters.
module pipeline_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       if_id_rn,
    input  logic [4:0]       if_id_rm,
    input  logic             if_id_uses_rm,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_flush,
    output logic             mem_wb_bubble,
    output logic             mem_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               mem_err_q, mem_err_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   flush_q, flush_d;

    logic load_use_s, mem_stall_s;
    logic freeze_s, branch_s, lu_s;
    logic stall_inc_s, flush_inc_s;

    // XZR reads as zero, so a load targeting X31 can never feed a dependent.
    assign load_use_s  = id_ex_memread && (id_ex_rd != 5'd31) &&
                         ((id_ex_rd == if_id_rn) || (if_id_uses_rm && (id_ex_rd == if_id_rm)));
    assign mem_stall_s = dmem_req && !dmem_ready;

    // Next-state, wait/timeout tracking and per-cycle control intent.
    always_comb begin
        freeze_s    = 1'b0;
        branch_s    = 1'b0;
        lu_s        = 1'b0;
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
        state_d     = state_q;
        wait_d      = wait_q;
        mem_err_d   = mem_err_q;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if ((state_q == ST_MEM_WAIT) && !dmem_ready) begin
                    freeze_s    = 1'b1;
                    stall_inc_s = 1'b1;
                    wait_d      = wait_q + WAIT_ONE;
                    if (wait_q >= WAIT_LAST) begin
                        mem_err_d = 1'b1;
                        state_d   = ST_HALT;
                    end else begin
                        state_d   = ST_MEM_WAIT;
                    end
                end else if ((state_q == ST_RUN) && mem_stall_s) begin
                    freeze_s    = 1'b1;
                    stall_inc_s = 1'b1;
                    wait_d      = WAIT_ONE;
                    state_d     = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    branch_s    = 1'b1;
                    flush_inc_s = 1'b1;
                    wait_d      = '0;
                    state_d     = ST_FLUSH;
                end else if (load_use_s) begin
                    lu_s        = 1'b1;
                    stall_inc_s = 1'b1;
                    wait_d      = '0;
                    state_d     = ST_RUN;
                end else begin
                    wait_d      = '0;
                    state_d     = ST_RUN;
                end
            end
            // IF/ID holds a bubble here, so only the memory port can stall us.
            ST_FLUSH: begin
                if (mem_stall_s) begin
                    freeze_s    = 1'b1;
                    stall_inc_s = 1'b1;
                    wait_d      = WAIT_ONE;
                    state_d     = ST_MEM_WAIT;
                end else begin
                    state_d     = ST_RUN;
                end
            end
            ST_HALT: begin
                freeze_s = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase

        if (stall_inc_s && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end else begin
            stall_d = stall_q;
        end
        if (flush_inc_s && (flush_q != CNT_MAX)) begin
            flush_d = flush_q + CNT_ONE;
        end else begin
            flush_d = flush_q;
        end
    end

    // Controller state and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    // While reset is held every register stays closed and every stage is cleared.
    assign pc_write      = reset_n & ~(freeze_s | lu_s);
    assign if_id_write   = reset_n & ~(freeze_s | lu_s);
    assign id_ex_write   = reset_n & ~freeze_s;
    assign ex_mem_write  = reset_n & ~freeze_s;
    assign if_id_flush   = ~reset_n | branch_s;
    assign id_ex_bubble  = ~reset_n | branch_s | lu_s;
    assign ex_mem_flush  = ~reset_n | branch_s;
    assign mem_wb_bubble = ~reset_n | freeze_s;

    assign state       = state_q;
    assign mem_err     = mem_err_q;
    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// compared against a rule-level reference model of the controller.
module tb_pipeline_ctrl;

    localparam int CW  = 5;
    localparam int TO  = 16;
    localparam int SAT = (1 << CW) - 1;

    localparam logic [7:0] C_FREEZE = 8'b0000_0001;
    localparam logic [7:0] C_DEFLT  = 8'b1111_0000;
    localparam logic [7:0] C_BRANCH = 8'b1111_1110;
    localparam logic [7:0] C_LU     = 8'b0011_0100;
    localparam logic [7:0] C_RESET  = 8'b0000_1111;

    localparam int A_DEF = 0, A_LU = 1, A_BR = 2, A_ENTER = 3, A_WAIT = 4, A_HALT = 5;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          id_ex_memread, if_id_uses_rm, branch_taken, dmem_req, dmem_ready;
    logic [4:0]    id_ex_rd, if_id_rn, if_id_rm;
    logic          pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic          if_id_flush, id_ex_bubble, ex_mem_flush, mem_wb_bubble, mem_err;
    logic [1:0]    state;
    logic [CW-1:0] stall_count, flush_count;

    int total = 0;
    int bad   = 0;

    int m_state, m_wait, m_stall, m_flush;
    bit m_err;

    wire [7:0]  obs_ctrl = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                            if_id_flush, id_ex_bubble, ex_mem_flush, mem_wb_bubble};
    wire [20:0] obs      = {obs_ctrl, state, mem_err, stall_count, flush_count};

    always #5 clock = ~clock;

    pipeline_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .if_id_rn(if_id_rn), .if_id_rm(if_id_rm), .if_id_uses_rm(if_id_uses_rm),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .ex_mem_flush(ex_mem_flush), .mem_wb_bubble(mem_wb_bubble), .mem_err(mem_err),
        .state(state), .stall_count(stall_count), .flush_count(flush_count)
    );

    function automatic int m_action();
        bit lu, ms;
        lu = id_ex_memread && (id_ex_rd != 5'd31) &&
             ((id_ex_rd == if_id_rn) || (if_id_uses_rm && (id_ex_rd == if_id_rm)));
        ms = dmem_req && !dmem_ready;
        if (m_state == 3) return A_HALT;
        if (m_state == 2) return ms ? A_ENTER : A_DEF;
        if (m_state == 1 && !dmem_ready) return A_WAIT;
        if (m_state == 0 && ms) return A_ENTER;
        if (branch_taken) return A_BR;
        if (lu) return A_LU;
        return A_DEF;
    endfunction

    function automatic logic [20:0] expv();
        logic [7:0] c;
        case (m_action())
            A_LU:                    c = C_LU;
            A_BR:                    c = C_BRANCH;
            A_ENTER, A_WAIT, A_HALT: c = C_FREEZE;
            default:                 c = C_DEFLT;
        endcase
        if (!reset_n) c = C_RESET;
        return {c, 2'(m_state), m_err, CW'(m_stall), CW'(m_flush)};
    endfunction

    task automatic m_reset();
        m_state = 0; m_wait = 0; m_err = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic advance();
        int a;
        a = m_action();
        @(posedge clock);
        case (a)
            A_ENTER: begin m_state = 1; m_wait = 1; if (m_stall < SAT) m_stall++; end
            A_WAIT: begin
                if (m_stall < SAT) m_stall++;
                m_wait++;
                if (m_wait == TO) begin m_err = 1; m_state = 3; end
            end
            A_BR:    begin m_state = 2; m_wait = 0; if (m_flush < SAT) m_flush++; end
            A_LU:    begin m_state = 0; m_wait = 0; if (m_stall < SAT) m_stall++; end
            A_HALT:  ;
            default: begin m_state = 0; m_wait = 0; end
        endcase
        #1;
    endtask

    task automatic clear_inputs();
        id_ex_memread = 1'b0; id_ex_rd = 5'd0; if_id_rn = 5'd0; if_id_rm = 5'd0;
        if_id_uses_rm = 1'b0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        m_reset();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        total++;
        if (obs !== {C_DEFLT, 2'd0, 1'b0, 5'd0, 5'd0}) begin
            bad++; $display("FAIL reset_idle: got %b expected %b", obs, {C_DEFLT, 2'd0, 1'b0, 5'd0, 5'd0});
        end
        dmem_req = 1'b1; dmem_ready = 1'b0;
        advance(); advance();
        @(negedge clock);
        total++;
        if ({state, stall_count} !== {2'd1, 5'd2}) begin
            bad++; $display("FAIL reset_prewait: got %b expected %b", {state, stall_count}, {2'd1, 5'd2});
        end
        #2;
        reset_n = 1'b0;
        m_reset();
        #1;
        total++;
        if (obs !== {C_RESET, 2'd0, 1'b0, 5'd0, 5'd0}) begin
            bad++; $display("FAIL reset_async: got %b expected %b", obs, {C_RESET, 2'd0, 1'b0, 5'd0, 5'd0});
        end
        @(posedge clock); #1;
        total++;
        if (obs !== expv()) begin
            bad++; $display("FAIL reset_held: got %b expected %b", obs, expv());
        end
        clear_inputs();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_load_use();
        do_reset();
        id_ex_memread = 1'b1; id_ex_rd = 5'd2; if_id_rn = 5'd2; if_id_rm = 5'd4; if_id_uses_rm = 1'b1;
        @(negedge clock);
        total++;
        if (obs_ctrl !== C_LU || obs !== expv()) begin
            bad++; $display("FAIL load_use_stall: got %b expected %b", obs, expv());
        end
        advance();
        id_ex_memread = 1'b0;
        @(negedge clock);
        total++;
        if (obs_ctrl !== C_DEFLT || stall_count !== 5'd1 || obs !== expv()) begin
            bad++; $display("FAIL load_use_release: got %b expected %b", obs, expv());
        end
        advance();
    endtask

    task automatic test_no_hazard();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            id_ex_memread = 1'b1;
            id_ex_rd      = (k == 0) ? 5'd31 : 5'd5;
            if_id_rn      = (k == 0) ? 5'd31 : 5'd0;
            if_id_rm      = (k == 0) ? 5'd31 : 5'd5;
            if_id_uses_rm = (k == 2);
            @(negedge clock);
            total++;
            if (obs_ctrl !== ((k == 2) ? C_LU : C_DEFLT) || obs !== expv()) begin
                bad++; $display("FAIL no_hazard_%0d: got %b expected %b", k, obs, expv());
            end
            advance();
        end
        @(negedge clock);
        total++;
        if (stall_count !== 5'd1) begin
            bad++; $display("FAIL no_hazard_count: got %0d expected 1", stall_count);
        end
    endtask

    task automatic test_branch();
        do_reset();
        branch_taken = 1'b1;
        @(negedge clock);
        total++;
        if (obs_ctrl !== C_BRANCH || obs !== expv()) begin
            bad++; $display("FAIL branch_flush: got %b expected %b", obs, expv());
        end
        advance();
        id_ex_memread = 1'b1; id_ex_rd = 5'd2; if_id_rn = 5'd2;
        @(negedge clock);
        total++;
        if ({obs_ctrl, state} !== {C_DEFLT, 2'd2} || obs !== expv()) begin
            bad++; $display("FAIL branch_flush_state: got %b expected %b", obs, expv());
        end
        advance();
        clear_inputs();
        @(negedge clock);
        total++;
        if ({state, stall_count, flush_count} !== {2'd0, 5'd0, 5'd1} || obs !== expv()) begin
            bad++; $display("FAIL branch_return: got %b expected %b", obs, expv());
        end
        advance();
    endtask

    task automatic test_mem_wait();
        do_reset();
        dmem_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dmem_ready = (k == 3);
            @(negedge clock);
            total++;
            if (obs_ctrl !== ((k == 3) ? C_DEFLT : C_FREEZE) ||
                state !== ((k == 0) ? 2'd0 : 2'd1) || obs !== expv()) begin
                bad++; $display("FAIL mem_wait_%0d: got %b expected %b", k, obs, expv());
            end
            advance();
        end
        dmem_req = 1'b0;
        @(negedge clock);
        total++;
        if ({state, stall_count} !== {2'd0, 5'd3}) begin
            bad++; $display("FAIL mem_wait_done: got %b expected %b", {state, stall_count}, {2'd0, 5'd3});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int k = 0; k < TO; k++) begin
            @(negedge clock);
            total++;
            if (obs_ctrl !== C_FREEZE || mem_err !== 1'b0 || obs !== expv()) begin
                bad++; $display("FAIL timeout_wait_%0d: got %b expected %b", k, obs, expv());
            end
            advance();
        end
        dmem_ready = 1'b1; branch_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            total++;
            if ({obs_ctrl, state, mem_err, stall_count} !== {C_FREEZE, 2'd3, 1'b1, 5'd16} || obs !== expv()) begin
                bad++; $display("FAIL timeout_halt_%0d: got %b expected %b", k, obs, expv());
            end
            advance();
        end
        do_reset();
        @(negedge clock);
        total++;
        if ({state, mem_err} !== {2'd0, 1'b0}) begin
            bad++; $display("FAIL timeout_recover: got %b expected 000", {state, mem_err});
        end
    endtask

    task automatic test_branch_vs_stall();
        do_reset();
        branch_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        @(negedge clock);
        total++;
        if (obs_ctrl !== C_FREEZE || obs !== expv()) begin
            bad++; $display("FAIL branch_vs_stall_freeze: got %b expected %b", obs, expv());
        end
        advance();
        dmem_ready = 1'b1;
        @(negedge clock);
        total++;
        if ({obs_ctrl, state} !== {C_BRANCH, 2'd1} || obs !== expv()) begin
            bad++; $display("FAIL branch_vs_stall_release: got %b expected %b", obs, expv());
        end
        advance();
        clear_inputs();
        @(negedge clock);
        total++;
        if ({state, flush_count, stall_count} !== {2'd2, 5'd1, 5'd1}) begin
            bad++; $display("FAIL branch_vs_stall_after: got %b expected %b",
                            {state, flush_count, stall_count}, {2'd2, 5'd1, 5'd1});
        end
        advance();
    endtask

    function automatic logic [4:0] pick_reg();
        logic [4:0] v;
        v = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 4) == 0) v = 5'd31;
        return v;
    endfunction

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            id_ex_memread = 1'($urandom_range(0, 1));
            id_ex_rd      = pick_reg();
            if_id_rn      = pick_reg();
            if_id_rm      = pick_reg();
            if_id_uses_rm = 1'($urandom_range(0, 1));
            branch_taken  = ($urandom_range(0, 4) == 0);
            dmem_req      = ($urandom_range(0, 2) == 0);
            dmem_ready    = ($urandom_range(0, 9) < 4);
            @(negedge clock);
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL random_%0d: got %b expected %b", i, obs, expv());
            end
            advance();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        m_reset();
        #12;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_branch_vs_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
